// File: rtl/io_dev_decoder.sv
// Fans the bridge's single classic-bus request out to NDEV one-hot peripheral slots, muxes ack/data back, and errors out unpopulated or silent slots.
// Latency: 2 + device latency clocks from request to s_ack_o; 1 clock for an unpopulated slot; every output is registered.
// Backpressure: s_stall_o stays high from request capture until the bridge drops s_stb_i after the ack. Optional error status is enabled by IO_DEV_ERR_IRQ_EN.
module io_dev_decoder #(
    parameter int              NDEV      = 8,
    parameter int              DEV_LSB   = 16,
    parameter logic [NDEV-1:0] DEV_MASK  = 8'h7F,
    parameter int              TO_CYCLES = 255,
    parameter logic [31:0]     ERR_DATA  = 32'hDEADBEEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              s_cyc_i,
    input  logic              s_stb_i,
    input  logic              s_we_i,
    input  logic [3:0]        s_sel_i,
    input  logic [31:0]       s_adr_i,
    input  logic [31:0]       s_dat_i,
    output logic              s_ack_o,
    output logic              s_stall_o,
    output logic [31:0]       s_dat_o,
    output logic [NDEV-1:0]   dev_cyc_o,
    output logic [NDEV-1:0]   dev_stb_o,
    output logic              dev_we_o,
    output logic [3:0]        dev_sel_o,
    output logic [31:0]       dev_adr_o,
    output logic [31:0]       dev_dat_o,
    input  logic [NDEV-1:0]   dev_ack_i,
    input  logic [NDEV*32-1:0] dev_dat_i,
    output logic              to_o,
    output logic [31:0]       err_adr_o
`ifdef IO_DEV_ERR_IRQ_EN
    ,
    input  logic              err_clr_i,
    output logic              err_irq_o,
    output logic [7:0]        err_cnt_o
`endif
);

    localparam int              IW      = $clog2(NDEV);
    localparam logic [15:0]     TO_LAST = 16'(TO_CYCLES - 1);
    localparam logic [NDEV-1:0] ONE     = NDEV'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   sel_idx;
    logic [15:0]     to_cnt;

    logic [IW-1:0]   req_idx;
    logic            req;
    logic            req_pop;
    logic            sel_ack;
    logic [31:0]     sel_dat;
    logic            to_hit;

    // Decode the incoming slot and pick the selected slot's ack/data.
    always_comb begin
        req_idx = s_adr_i[DEV_LSB +: IW];
        req     = s_cyc_i & s_stb_i;
        req_pop = DEV_MASK[req_idx];
        sel_ack = dev_ack_i[sel_idx];
        sel_dat = dev_dat_i[{sel_idx, 5'd0} +: 32];
        to_hit  = (to_cnt == TO_LAST);
    end

    // Request/response FSM; all bus outputs are registered here.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= ST_IDLE;
            sel_idx   <= '0;
            to_cnt    <= '0;
            s_ack_o   <= 1'b0;
            s_stall_o <= 1'b0;
            s_dat_o   <= '0;
            dev_cyc_o <= '0;
            dev_stb_o <= '0;
            dev_we_o  <= 1'b0;
            dev_sel_o <= '0;
            dev_adr_o <= '0;
            dev_dat_o <= '0;
            to_o      <= 1'b0;
            err_adr_o <= '0;
        end else begin
            to_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        dev_we_o  <= s_we_i;
                        dev_sel_o <= s_sel_i;
                        dev_adr_o <= s_adr_i;
                        dev_dat_o <= s_dat_i;
                        s_stall_o <= 1'b1;
                        sel_idx   <= req_idx;
                        if (req_pop) begin
                            dev_cyc_o <= ONE << req_idx;
                            dev_stb_o <= ONE << req_idx;
                            to_cnt    <= '0;
                            state     <= ST_ACTIVE;
                        end else begin
                            // Nothing lives at this slot: answer at once with an error.
                            s_ack_o   <= 1'b1;
                            s_dat_o   <= ERR_DATA;
                            err_adr_o <= s_adr_i;
                            state     <= ST_RESP;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (!s_cyc_i) begin
                        // Bridge abandoned the cycle: release the slot silently.
                        dev_cyc_o <= '0;
                        dev_stb_o <= '0;
                        s_stall_o <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (sel_ack) begin
                        // Ack is checked before the timeout so a last-cycle ack still wins.
                        dev_cyc_o <= '0;
                        dev_stb_o <= '0;
                        s_ack_o   <= 1'b1;
                        s_dat_o   <= sel_dat;
                        state     <= ST_RESP;
                    end else if (to_hit) begin
                        dev_cyc_o <= '0;
                        dev_stb_o <= '0;
                        s_ack_o   <= 1'b1;
                        s_dat_o   <= ERR_DATA;
                        to_o      <= 1'b1;
                        err_adr_o <= dev_adr_o;
                        state     <= ST_RESP;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                ST_RESP: begin
                    // Hold the response until the bridge lowers its strobe.
                    if (!s_stb_i) begin
                        s_ack_o   <= 1'b0;
                        s_dat_o   <= '0;
                        s_stall_o <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef IO_DEV_ERR_IRQ_EN
    logic err_evt;

    // An error response is issued on this edge (unpopulated slot or timeout).
    always_comb begin
        err_evt = ((state == ST_IDLE) && req && !req_pop) ||
                  ((state == ST_ACTIVE) && s_cyc_i && !sel_ack && to_hit);
    end

    // Sticky error flag and saturating error count; a new error beats a clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_irq_o <= 1'b0;
            err_cnt_o <= '0;
        end else begin
            if (err_evt)
                err_irq_o <= 1'b1;
            else if (err_clr_i)
                err_irq_o <= 1'b0;

            if (err_clr_i)
                err_cnt_o <= err_evt ? 8'd1 : 8'd0;
            else if (err_evt && (err_cnt_o != 8'hFF))
                err_cnt_o <= err_cnt_o + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_io_dev_decoder.sv
// Directed bench for io_dev_decoder: reset, read, write, unpopulated, timeout, ack/timeout race, foreign ack, abort, reset mid-cycle.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
// Prints one summary line and finishes.
module tb_io_dev_decoder;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          s_cyc_i, s_stb_i, s_we_i;
    logic [3:0]    s_sel_i;
    logic [31:0]   s_adr_i, s_dat_i;
    logic          s_ack_o, s_stall_o;
    logic [31:0]   s_dat_o;
    logic [7:0]    dev_cyc_o, dev_stb_o;
    logic          dev_we_o;
    logic [3:0]    dev_sel_o;
    logic [31:0]   dev_adr_o, dev_dat_o;
    logic [7:0]    dev_ack_i;
    logic [255:0]  dev_dat_i;
    logic          to_o;
    logic [31:0]   err_adr_o;
`ifdef IO_DEV_ERR_IRQ_EN
    logic          err_clr_i = 1'b0;
    logic          err_irq_o;
    logic [7:0]    err_cnt_o;
`endif

    int tests = 0;
    int fails = 0;

    io_dev_decoder dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i), .s_sel_i(s_sel_i),
        .s_adr_i(s_adr_i), .s_dat_i(s_dat_i),
        .s_ack_o(s_ack_o), .s_stall_o(s_stall_o), .s_dat_o(s_dat_o),
        .dev_cyc_o(dev_cyc_o), .dev_stb_o(dev_stb_o), .dev_we_o(dev_we_o),
        .dev_sel_o(dev_sel_o), .dev_adr_o(dev_adr_o), .dev_dat_o(dev_dat_o),
        .dev_ack_i(dev_ack_i), .dev_dat_i(dev_dat_i),
        .to_o(to_o), .err_adr_o(err_adr_o)
`ifdef IO_DEV_ERR_IRQ_EN
        , .err_clr_i(err_clr_i), .err_irq_o(err_irq_o), .err_cnt_o(err_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present a request; returns in cycle T0+1 (just after the sampling edge).
    task automatic issue(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                         input logic [31:0] dat);
        s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = we; s_sel_i = sel;
        s_adr_i = adr;  s_dat_i = dat;
        tick();
    endtask

    task automatic release_bus();
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        s_cyc_i = 0; s_stb_i = 0; s_we_i = 0; s_sel_i = 0; s_adr_i = 0; s_dat_i = 0;
        dev_ack_i = 0; dev_dat_i = '0;
        #12;
        tests++; if (s_ack_o !== 1'b0) begin fails++; $display("FAIL reset_ack got %b want 0", s_ack_o); end
        tests++; if (s_stall_o !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", s_stall_o); end
        tests++; if (dev_cyc_o !== 8'h00) begin fails++; $display("FAIL reset_cyc got %h want 00", dev_cyc_o); end
        tests++; if (s_dat_o !== 32'h0) begin fails++; $display("FAIL reset_dat got %h want 0", s_dat_o); end
        tests++; if ({to_o, err_adr_o, dev_adr_o} !== 65'h0) begin fails++; $display("FAIL reset_misc got %h want 0", {to_o, err_adr_o, dev_adr_o}); end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_read();
        issue(32'hFD03_0010, 1'b0, 4'hF, 32'h0);
        tests++; if (dev_stb_o !== 8'h08) begin fails++; $display("FAIL read_stb got %h want 08", dev_stb_o); end
        tests++; if (s_stall_o !== 1'b1) begin fails++; $display("FAIL read_stall got %b want 1", s_stall_o); end
        tests++; if (dev_adr_o !== 32'hFD03_0010) begin fails++; $display("FAIL read_adr got %h want fd030010", dev_adr_o); end
        tick(); tick();                                   // cycle T0+3: device acks
        tests++; if (s_ack_o !== 1'b0) begin fails++; $display("FAIL read_early_ack got %b want 0", s_ack_o); end
        dev_ack_i = 8'h08; dev_dat_i[3*32 +: 32] = 32'h1234_5678;
        tick();                                           // cycle T0+4
        dev_ack_i = 8'h00;
        tests++; if (s_ack_o !== 1'b1 || s_dat_o !== 32'h1234_5678) begin fails++; $display("FAIL read_ack got %b/%h want 1/12345678", s_ack_o, s_dat_o); end
        tests++; if (dev_stb_o !== 8'h00) begin fails++; $display("FAIL read_stb_drop got %h want 00", dev_stb_o); end
        tick();
        tests++; if (s_ack_o !== 1'b1 || s_dat_o !== 32'h1234_5678) begin fails++; $display("FAIL read_hold got %b/%h want 1/12345678", s_ack_o, s_dat_o); end
        release_bus();
        tests++; if (s_ack_o !== 1'b0 || s_dat_o !== 32'h0 || s_stall_o !== 1'b0) begin fails++; $display("FAIL read_end got %b/%h/%b want 0/0/0", s_ack_o, s_dat_o, s_stall_o); end
    endtask

    task automatic test_write();
        issue(32'hFD00_0004, 1'b1, 4'h3, 32'hA5A5_0000);
        tests++; if (dev_we_o !== 1'b1 || dev_sel_o !== 4'h3) begin fails++; $display("FAIL write_we_sel got %b/%h want 1/3", dev_we_o, dev_sel_o); end
        tests++; if (dev_dat_o !== 32'hA5A5_0000) begin fails++; $display("FAIL write_dat got %h want a5a50000", dev_dat_o); end
        tests++; if (dev_cyc_o !== 8'h01) begin fails++; $display("FAIL write_cyc got %h want 01", dev_cyc_o); end
        dev_ack_i = 8'h01; dev_dat_i[0 +: 32] = 32'h0000_0055;
        tick();
        dev_ack_i = 8'h00;
        tests++; if (s_ack_o !== 1'b1 || s_dat_o !== 32'h0000_0055) begin fails++; $display("FAIL write_ack got %b/%h want 1/00000055", s_ack_o, s_dat_o); end
        release_bus();
    endtask

    task automatic test_unpopulated();
        issue(32'hFD07_0000, 1'b0, 4'hF, 32'h0);
        tests++; if (dev_cyc_o !== 8'h00 || dev_stb_o !== 8'h00) begin fails++; $display("FAIL unpop_stb got %h/%h want 00/00", dev_cyc_o, dev_stb_o); end
        tests++; if (s_ack_o !== 1'b1 || s_dat_o !== 32'hDEADBEEF) begin fails++; $display("FAIL unpop_ack got %b/%h want 1/deadbeef", s_ack_o, s_dat_o); end
        tests++; if (err_adr_o !== 32'hFD07_0000) begin fails++; $display("FAIL unpop_err_adr got %h want fd070000", err_adr_o); end
        tests++; if (to_o !== 1'b0) begin fails++; $display("FAIL unpop_to got %b want 0", to_o); end
        release_bus();
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        issue(32'hFD02_0000, 1'b0, 4'hF, 32'h0);
        for (int i = 1; i <= 254; i++) begin
            tick();
            if (s_ack_o !== 1'b0 || to_o !== 1'b0) early++;
        end
        tests++; if (early !== 0) begin fails++; $display("FAIL to_early got %0d early cycles want 0", early); end
        tick();                                           // cycle T0+256
        tests++; if (s_ack_o !== 1'b1 || s_dat_o !== 32'hDEADBEEF) begin fails++; $display("FAIL to_ack got %b/%h want 1/deadbeef", s_ack_o, s_dat_o); end
        tests++; if (to_o !== 1'b1 || dev_cyc_o !== 8'h00) begin fails++; $display("FAIL to_pulse got %b/%h want 1/00", to_o, dev_cyc_o); end
        tests++; if (err_adr_o !== 32'hFD02_0000) begin fails++; $display("FAIL to_err_adr got %h want fd020000", err_adr_o); end
        tick();
        tests++; if (to_o !== 1'b0 || s_ack_o !== 1'b1) begin fails++; $display("FAIL to_one_cycle got %b/%b want 0/1", to_o, s_ack_o); end
        release_bus();
    endtask

    task automatic test_ack_at_timeout();
        issue(32'hFD05_0000, 1'b0, 4'hF, 32'h0);
        for (int i = 1; i <= 254; i++) tick();            // cycle T0+255: last chance
        dev_ack_i = 8'h20; dev_dat_i[5*32 +: 32] = 32'hCAFE_0005;
        tick();
        dev_ack_i = 8'h00;
        tests++; if (s_ack_o !== 1'b1 || s_dat_o !== 32'hCAFE_0005) begin fails++; $display("FAIL race_ack got %b/%h want 1/cafe0005", s_ack_o, s_dat_o); end
        tests++; if (to_o !== 1'b0) begin fails++; $display("FAIL race_to got %b want 0", to_o); end
        release_bus();
    endtask

    task automatic test_foreign_ack();
        int bad;
        bad = 0;
        issue(32'hFD04_0000, 1'b0, 4'hF, 32'h0);
        dev_ack_i = 8'h02; dev_dat_i[1*32 +: 32] = 32'h1111_1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (s_ack_o !== 1'b0 || dev_stb_o !== 8'h10) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL foreign_ignored got %0d bad cycles want 0", bad); end
        dev_ack_i = 8'h10; dev_dat_i[4*32 +: 32] = 32'h4444_4444;
        tick();
        dev_ack_i = 8'h00;
        tests++; if (s_ack_o !== 1'b1 || s_dat_o !== 32'h4444_4444) begin fails++; $display("FAIL foreign_own_ack got %b/%h want 1/44444444", s_ack_o, s_dat_o); end
        release_bus();
    endtask

    task automatic test_abort();
        int acks;
        acks = 0;
        issue(32'hFD06_0000, 1'b0, 4'hF, 32'h0);
        tick(); tick();                                   // three cycles into ACTIVE
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
        tick();
        tests++; if (dev_cyc_o !== 8'h00 || dev_stb_o !== 8'h00) begin fails++; $display("FAIL abort_drop got %h/%h want 00/00", dev_cyc_o, dev_stb_o); end
        for (int i = 0; i < 4; i++) begin
            if (s_ack_o !== 1'b0) acks++;
            tick();
        end
        tests++; if (acks !== 0) begin fails++; $display("FAIL abort_no_ack got %0d ack cycles want 0", acks); end
        issue(32'hFD03_0000, 1'b0, 4'hF, 32'h0);
        dev_ack_i = 8'h08; dev_dat_i[3*32 +: 32] = 32'h3333_0001;
        tick();
        dev_ack_i = 8'h00;
        tests++; if (s_ack_o !== 1'b1 || s_dat_o !== 32'h3333_0001) begin fails++; $display("FAIL abort_next got %b/%h want 1/33330001", s_ack_o, s_dat_o); end
        release_bus();
    endtask

    task automatic test_reset_mid_active();
        issue(32'hFD01_0000, 1'b0, 4'hF, 32'h0);
        tick();
        #2 rst_ni = 1'b0;
        #1;
        tests++; if (dev_cyc_o !== 8'h00 || dev_stb_o !== 8'h00 || s_stall_o !== 1'b0) begin fails++; $display("FAIL rst_mid got %h/%h/%b want 00/00/0", dev_cyc_o, dev_stb_o, s_stall_o); end
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
        #2 rst_ni = 1'b1;
        tick();
        tests++; if (s_ack_o !== 1'b0) begin fails++; $display("FAIL rst_mid_ack got %b want 0", s_ack_o); end
        issue(32'hFD00_0000, 1'b0, 4'hF, 32'h0);
        tests++; if (dev_cyc_o !== 8'h01) begin fails++; $display("FAIL rst_next_cyc got %h want 01", dev_cyc_o); end
        dev_ack_i = 8'h01; dev_dat_i[0 +: 32] = 32'h0BAD_F00D;
        tick();
        dev_ack_i = 8'h00;
        tests++; if (s_ack_o !== 1'b1 || s_dat_o !== 32'h0BAD_F00D) begin fails++; $display("FAIL rst_next_ack got %b/%h want 1/0badf00d", s_ack_o, s_dat_o); end
        release_bus();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_unpopulated();
        test_timeout();
        test_ack_at_timeout();
        test_foreign_ack();
        test_abort();
        test_reset_mid_active();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
